// File: rtl/ps2_move_sequencer.sv
// rtl/ps2_move_sequencer.sv - PS/2 arrow-key decoder and tick-driven sprite position sequencer
//
// Decodes the PS/2 scancode byte stream (E0 extended and F0 break prefixes),
// keeps held flags for the four arrow keys, and on every movement tick steps
// the (pos_x, pos_y) position by STEP pixels per axis within the screen bounds.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   byte_in     received scancode byte
//   byte_valid  one-cycle strobe, byte_in valid this cycle
//   pos_x       sprite x position (0..X_MAX)
//   pos_y       sprite y position (0..Y_MAX)
//   left        left arrow held  (code 6B)
//   right       right arrow held (code 74)
//   up          up arrow held    (code 75)
//   down        down arrow held  (code 72)
//   move_pulse  one-cycle strobe, high in the first cycle showing a new position
//
// Optional feature macro: PS2_MOVE_WRAP_EN
//   defined   - position wraps to the opposite bound instead of clamping, and
//               move_pulse fires on every tick with motion requested
//   undefined - position clamps at the bounds, move_pulse only on real change

module ps2_move_sequencer #(
    parameter int X_MAX    = 639,
    parameter int Y_MAX    = 479,
    parameter int X_INIT   = 320,
    parameter int Y_INIT   = 240,
    parameter int STEP     = 4,
    parameter int TICK_DIV = 833333
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       left,
    output logic       right,
    output logic       up,
    output logic       down,
    output logic       move_pulse
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_RIGHT = 8'h74;
    localparam logic [7:0] CODE_UP    = 8'h75;
    localparam logic [7:0] CODE_DOWN  = 8'h72;

    localparam logic [10:0] STEP11   = 11'(STEP);
    localparam logic [10:0] X_MAX11  = 11'(X_MAX);
    localparam logic [10:0] Y_MAX11  = 11'(Y_MAX);
    localparam logic [10:0] X_LIM11  = 11'(X_MAX - STEP);
    localparam logic [10:0] Y_LIM11  = 11'(Y_MAX - STEP);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } state_t;

    state_t state, state_nxt;
    logic   make_ev, break_ev;

    logic [CW-1:0] cnt;
    logic          tick;

    logic [10:0] x11, y11, x_sum, y_sum;
    logic [9:0]  x_nxt, y_nxt;
    logic        x_req, y_req, moved;

    // ---------------- prefix FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        make_ev   = 1'b0;
        break_ev  = 1'b0;
        if (byte_valid) begin
            case (state)
                IDLE: begin
                    if (byte_in == CODE_EXT) begin
                        state_nxt = EXT;
                    end else if (byte_in == CODE_BRK) begin
                        state_nxt = BRK;
                    end else begin
                        make_ev = 1'b1;
                    end
                end
                EXT: begin
                    if (byte_in == CODE_BRK) begin
                        state_nxt = EXT_BRK;
                    end else if (byte_in == CODE_EXT) begin
                        state_nxt = EXT;
                    end else begin
                        make_ev   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                BRK: begin
                    // A stray prefix after F0 just abandons the break; being
                    // non-arrow codes, decoding them as a break changes nothing.
                    break_ev  = 1'b1;
                    state_nxt = IDLE;
                end
                EXT_BRK: begin
                    break_ev  = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ---------------- held-key flags ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left  <= 1'b0;
            right <= 1'b0;
            up    <= 1'b0;
            down  <= 1'b0;
        end else if (make_ev || break_ev) begin
            case (byte_in)
                CODE_LEFT:  left  <= make_ev;
                CODE_RIGHT: right <= make_ev;
                CODE_UP:    up    <= make_ev;
                CODE_DOWN:  down  <= make_ev;
                default: ;
            endcase
        end
    end

    // ---------------- movement tick ----------------
    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // ---------------- next position ----------------
    // Bounds are compared in 11 bits before truncating so that x+STEP near
    // X_MAX and x<STEP near zero never alias inside the 10-bit range.
    assign x11   = {1'b0, pos_x};
    assign y11   = {1'b0, pos_y};
    assign x_sum = x11 + STEP11;
    assign y_sum = y11 + STEP11;
    assign x_req = left ^ right;
    assign y_req = up ^ down;

    always_comb begin
        x_nxt = pos_x;
        if (left && !right) begin
            if (x11 < STEP11) begin
`ifdef PS2_MOVE_WRAP_EN
                x_nxt = X_MAX11[9:0];
`else
                x_nxt = 10'd0;
`endif
            end else begin
                x_nxt = pos_x - STEP11[9:0];
            end
        end else if (right && !left) begin
            if (x11 > X_LIM11) begin
`ifdef PS2_MOVE_WRAP_EN
                x_nxt = 10'd0;
`else
                x_nxt = X_MAX11[9:0];
`endif
            end else begin
                x_nxt = x_sum[9:0];
            end
        end
    end

    always_comb begin
        y_nxt = pos_y;
        if (up && !down) begin
            if (y11 < STEP11) begin
`ifdef PS2_MOVE_WRAP_EN
                y_nxt = Y_MAX11[9:0];
`else
                y_nxt = 10'd0;
`endif
            end else begin
                y_nxt = pos_y - STEP11[9:0];
            end
        end else if (down && !up) begin
            if (y11 > Y_LIM11) begin
`ifdef PS2_MOVE_WRAP_EN
                y_nxt = 10'd0;
`else
                y_nxt = Y_MAX11[9:0];
`endif
            end else begin
                y_nxt = y_sum[9:0];
            end
        end
    end

`ifdef PS2_MOVE_WRAP_EN
    assign moved = x_req | y_req;
`else
    assign moved = (x_nxt != pos_x) | (y_nxt != pos_y);
`endif

    // Position uses the flags as registered before this cycle, so a byte
    // arriving on a tick cycle only affects the following tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x      <= 10'(X_INIT);
            pos_y      <= 10'(Y_INIT);
            move_pulse <= 1'b0;
        end else begin
            move_pulse <= tick & moved;
            if (tick) begin
                pos_x <= x_nxt;
                pos_y <= y_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ps2_move_sequencer.sv
// tb/tb_ps2_move_sequencer.sv - randomized self-checking bench for ps2_move_sequencer

module tb_ps2_move_sequencer;

    localparam int XM = 639;
    localparam int YM = 479;
    localparam int XI = 320;
    localparam int YI = 240;
    localparam int ST = 4;
    localparam int TD = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic [9:0] pos_x, pos_y;
    logic       left, right, up, down, move_pulse;

    int vecs;
    int errs;

    // reference model state
    int m_x, m_y, m_n;
    bit m_l, m_r, m_u, m_d, m_brk, m_pulse;
    int pulse_cnt;

    ps2_move_sequencer #(
        .X_MAX(XM), .Y_MAX(YM), .X_INIT(XI), .Y_INIT(YI),
        .STEP(ST), .TICK_DIV(TD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .pos_x(pos_x), .pos_y(pos_y), .left(left), .right(right),
        .up(up), .down(down), .move_pulse(move_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int axis_step(input int p, input int dir, input int lim);
        int n;
        n = p + dir * ST;
`ifdef PS2_MOVE_WRAP_EN
        if (n < 0) n = lim;
        else if (n > lim) n = 0;
`else
        if (n < 0) n = 0;
        else if (n > lim) n = lim;
`endif
        return n;
    endfunction

    task automatic model_reset();
        m_x = XI; m_y = YI; m_n = 0;
        m_l = 0; m_r = 0; m_u = 0; m_d = 0;
        m_brk = 0; m_pulse = 0;
    endtask

    // One clock: drive inputs, advance model, compare all outputs at negedge.
    task automatic run_cycle(input bit v, input logic [7:0] b);
        int dx, dy, nx, ny;
        bit make;
        byte_valid = v;
        byte_in    = b;
        @(posedge clk);
        m_pulse = 0;
        if ((m_n % TD) == TD - 1) begin
            dx = int'(m_r && !m_l) - int'(m_l && !m_r);
            dy = int'(m_d && !m_u) - int'(m_u && !m_d);
            nx = axis_step(m_x, dx, XM);
            ny = axis_step(m_y, dy, YM);
`ifdef PS2_MOVE_WRAP_EN
            m_pulse = (dx != 0) || (dy != 0);
`else
            m_pulse = (nx != m_x) || (ny != m_y);
`endif
            m_x = nx; m_y = ny;
        end
        if (v) begin
            if (m_brk) begin
                m_brk = 0;
                make  = 0;
                case (b)
                    8'h6B: m_l = 0;
                    8'h74: m_r = 0;
                    8'h75: m_u = 0;
                    8'h72: m_d = 0;
                    default: ;
                endcase
            end else if (b == 8'hF0) begin
                m_brk = 1;
            end else if (b != 8'hE0) begin
                make = 1;
                case (b)
                    8'h6B: m_l = make;
                    8'h74: m_r = make;
                    8'h75: m_u = make;
                    8'h72: m_d = make;
                    default: ;
                endcase
            end
        end
        m_n++;
        @(negedge clk);
        byte_valid = 1'b0;
        vecs++;
        if (pos_x !== 10'(m_x)) begin errs++; $display("FAIL pos_x cyc%0d: got %0d want %0d", m_n, pos_x, m_x); end
        if (pos_y !== 10'(m_y)) begin errs++; $display("FAIL pos_y cyc%0d: got %0d want %0d", m_n, pos_y, m_y); end
        if ({left, right, up, down} !== {m_l, m_r, m_u, m_d}) begin
            errs++; $display("FAIL flags cyc%0d: got %b want %b", m_n, {left, right, up, down}, {m_l, m_r, m_u, m_d});
        end
        if (move_pulse !== m_pulse) begin errs++; $display("FAIL move_pulse cyc%0d: got %b want %b", m_n, move_pulse, m_pulse); end
        if (move_pulse === 1'b1) pulse_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 8'h00);
    endtask

    // Asynchronous reset asserted between edges; checked before any clock edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        byte_valid = 1'b0;
        #1;
        vecs++;
        if ({pos_x, pos_y} !== {10'(XI), 10'(YI)} || {left, right, up, down, move_pulse} !== 5'b0) begin
            errs++;
            $display("FAIL async_reset: got pos=(%0d,%0d) flags=%b pulse=%b want (%0d,%0d) 0000 0",
                     pos_x, pos_y, {left, right, up, down}, move_pulse, XI, YI);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        pulse_cnt = 0;
        idle(20 * TD);
        vecs++;
        if (pulse_cnt !== 0) begin errs++; $display("FAIL idle_pulses: got %0d want 0", pulse_cnt); end
    endtask

    task automatic test_left_ext();
        int held_x;
        do_reset();
        pulse_cnt = 0;
        run_cycle(1'b1, 8'hE0);
        run_cycle(1'b1, 8'h6B);
        idle(3 * TD);
        vecs++;
        if (left !== 1'b1 || pos_x !== 10'd308 || pos_y !== 10'd240 || pulse_cnt !== 3) begin
            errs++;
            $display("FAIL ext_left: got left=%b x=%0d y=%0d pulses=%0d want 1 308 240 3", left, pos_x, pos_y, pulse_cnt);
        end
        run_cycle(1'b1, 8'hE0);
        run_cycle(1'b1, 8'hF0);
        run_cycle(1'b1, 8'h6B);
        held_x = pos_x;
        idle(3 * TD);
        vecs++;
        if (left !== 1'b0 || pos_x !== 10'(held_x)) begin
            errs++; $display("FAIL ext_release: got left=%b x=%0d want 0 %0d", left, pos_x, held_x);
        end
    endtask

    task automatic test_both_held();
        int x0;
        do_reset();
        run_cycle(1'b1, 8'h74);
        run_cycle(1'b1, 8'hE0);
        run_cycle(1'b1, 8'h6B);
        x0 = pos_x;
        idle(5 * TD);
        vecs++;
        if (pos_x !== 10'(x0)) begin errs++; $display("FAIL both_held: got x=%0d want %0d", pos_x, x0); end
        run_cycle(1'b1, 8'hE0);
        run_cycle(1'b1, 8'hF0);
        run_cycle(1'b1, 8'h74);
        x0 = pos_x;
        idle(4 * TD);
        vecs++;
        if (pos_x !== 10'(x0 - 4 * ST)) begin errs++; $display("FAIL left_only: got x=%0d want %0d", pos_x, x0 - 4 * ST); end
    endtask

    task automatic test_bounds();
        do_reset();
        run_cycle(1'b1, 8'h75);
        pulse_cnt = 0;
        idle(70 * TD);
        vecs++;
`ifdef PS2_MOVE_WRAP_EN
        if (pulse_cnt !== 70) begin errs++; $display("FAIL up_wrap_pulses: got %0d want 70", pulse_cnt); end
`else
        if (pos_y !== 10'd0 || pulse_cnt !== 60) begin
            errs++; $display("FAIL up_clamp: got y=%0d pulses=%0d want 0 60", pos_y, pulse_cnt);
        end
`endif
        // release up, drive right+down into the far corner
        run_cycle(1'b1, 8'hF0);
        run_cycle(1'b1, 8'h75);
        run_cycle(1'b1, 8'h74);
        run_cycle(1'b1, 8'h72);
        idle(130 * TD);
    endtask

    task automatic test_prefix_reset();
        do_reset();
        run_cycle(1'b1, 8'hE0);
        do_reset();
        run_cycle(1'b1, 8'h6B);
        vecs++;
        if (left !== 1'b1) begin errs++; $display("FAIL stale_ext: got left=%b want 1", left); end
        run_cycle(1'b1, 8'hF0);
        do_reset();
        run_cycle(1'b1, 8'h6B);
        vecs++;
        if (left !== 1'b1) begin errs++; $display("FAIL stale_brk: got left=%b want 1", left); end
    endtask

    task automatic test_same_cycle_tick();
        do_reset();
        idle(TD - 1);
        run_cycle(1'b1, 8'h72);
        vecs++;
        if (pos_y !== 10'd240 || down !== 1'b1) begin
            errs++; $display("FAIL tick_byte: got y=%0d down=%b want 240 1", pos_y, down);
        end
        idle(TD);
        vecs++;
        if (pos_y !== 10'(240 + ST)) begin errs++; $display("FAIL next_tick: got y=%0d want %0d", pos_y, 240 + ST); end
    endtask

    task automatic test_random();
        logic [7:0] tbl [6];
        logic [7:0] b;
        int k;
        tbl[0] = 8'hE0; tbl[1] = 8'hF0; tbl[2] = 8'h6B;
        tbl[3] = 8'h74; tbl[4] = 8'h75; tbl[5] = 8'h72;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, 6);
            b = (k == 6) ? 8'($urandom) : tbl[k];
            run_cycle(($urandom_range(0, 3) == 0), b);
        end
    endtask

    initial begin
        vecs = 0; errs = 0; pulse_cnt = 0;
        rst_n = 1'b1; byte_valid = 1'b0; byte_in = 8'h00;
        model_reset();
        @(negedge clk);
        test_reset();
        test_left_ext();
        test_both_held();
        test_bounds();
        test_prefix_reset();
        test_same_cycle_tick();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
